// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity selectors and line levels.
// The PARITY state is present only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

    localparam logic IDLE_LVL  = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Per-bit edge counter: bit_done_c marks the last CLK cycle of each serial bit.
// The counter is held at zero whenever the timer is disabled.
module uart_tx_bit_timer #(
    parameter int unsigned PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      en,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      bit_done_c
);

    logic [PRESCALE_WIDTH-1:0] edge_cnt;

    assign bit_done_c = en && (edge_cnt == (prescale - PRESCALE_WIDTH'(1)));

    always_ff @(posedge CLK) begin
        if (!RST) begin
            edge_cnt <= '0;
        end else if (!en || bit_done_c) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= edge_cnt + PRESCALE_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, LSB-first payload, optional parity, one stop bit.
// Define UART_TX_PARITY_EN to add the PAR_TYP port and the parity bit.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      Data_Valid,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
`ifdef UART_TX_PARITY_EN
    input  logic                      PAR_TYP,
`endif
    output logic                      TX_OUT,
    output logic                      Busy
);

    localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    state_t                    state;
    logic [DATA_WIDTH-1:0]     data_q;
    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic [IDX_W-1:0]          bit_idx;
    logic [IDX_W-1:0]          next_idx;
    logic                      bit_done;

    assign next_idx = bit_idx + IDX_W'(1);

`ifdef UART_TX_PARITY_EN
    logic par_typ_q;
    logic parity_bit_c;

    assign parity_bit_c = (^data_q) ^ (par_typ_q == PAR_ODD);
`endif

    uart_tx_bit_timer #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_bit_timer (
        .CLK        (CLK),
        .RST        (RST),
        .en         (state != ST_IDLE),
        .prescale   (prescale_q),
        .bit_done_c (bit_done)
    );

    // Frame sequencer; every bit advances only on the timer's last cycle of that bit.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= ST_IDLE;
            TX_OUT     <= IDLE_LVL;
            Busy       <= 1'b0;
            bit_idx    <= '0;
            data_q     <= '0;
            prescale_q <= '0;
`ifdef UART_TX_PARITY_EN
            par_typ_q  <= PAR_EVEN;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Data_Valid) begin
                        data_q     <= P_DATA;
                        prescale_q <= (Prescale == '0) ? PRESCALE_WIDTH'(1) : Prescale;
`ifdef UART_TX_PARITY_EN
                        par_typ_q  <= PAR_TYP;
`endif
                        bit_idx    <= '0;
                        state      <= ST_START;
                        TX_OUT     <= START_LVL;
                        Busy       <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_done) begin
                        state  <= ST_DATA;
                        TX_OUT <= data_q[0];
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        if (bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state  <= ST_PARITY;
                            TX_OUT <= parity_bit_c;
`else
                            state  <= ST_STOP;
                            TX_OUT <= STOP_LVL;
`endif
                        end else begin
                            bit_idx <= next_idx;
                            TX_OUT  <= data_q[next_idx];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_done) begin
                        state  <= ST_STOP;
                        TX_OUT <= STOP_LVL;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_done) begin
                        state  <= ST_IDLE;
                        TX_OUT <= IDLE_LVL;
                        Busy   <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    TX_OUT <= IDLE_LVL;
                    Busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Self-checking bench for uart_tx_framer against a per-cycle line/busy model.
// Builds with or without UART_TX_PARITY_EN.
module tb_uart_tx_framer;

    localparam int unsigned DW = 8;
    localparam int unsigned PW = 6;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid;
    logic [PW-1:0] Prescale;
`ifdef UART_TX_PARITY_EN
    logic          PAR_TYP;
`endif
    logic          TX_OUT;
    logic          Busy;

    int checks = 0;
    int errors = 0;

    logic exp_tx[$];
    logic exp_busy[$];

    uart_tx_framer #(
        .DATA_WIDTH     (DW),
        .PRESCALE_WIDTH (PW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .Prescale   (Prescale),
`ifdef UART_TX_PARITY_EN
        .PAR_TYP    (PAR_TYP),
`endif
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    // Expected line per cycle: start, LSB-first data, optional parity, stop; each held eff cycles.
    function automatic void add_frame(input logic [DW-1:0] d, input logic [PW-1:0] ps, input logic par);
        int   eff;
        logic bits[$];
        eff = (ps == 0) ? 1 : int'(ps);
        bits.push_back(1'b0);
        for (int i = 0; i < int'(DW); i++) bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        bits.push_back((^d) ^ par);
`else
        if (par === 1'bx) bits.push_back(1'bx);
`endif
        bits.push_back(1'b1);
        foreach (bits[b]) begin
            for (int r = 0; r < eff; r++) begin
                exp_tx.push_back(bits[b]);
                exp_busy.push_back(1'b1);
            end
        end
    endfunction

    function automatic void add_idle();
        exp_tx.push_back(1'b1);
        exp_busy.push_back(1'b0);
    endfunction

    task automatic test_reset;
        RST = 1'b0; Data_Valid = 1'b0; P_DATA = '0; Prescale = PW'(8);
`ifdef UART_TX_PARITY_EN
        PAR_TYP = 1'b0;
`endif
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: TX_OUT=%b Busy=%b, expected TX_OUT=1 Busy=0", TX_OUT, Busy);
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        checks++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: TX_OUT=%b Busy=%b, expected TX_OUT=1 Busy=0", TX_OUT, Busy);
        end
    endtask

    // Directed frames: A5/even/8, 00/odd/16, 3C/8, FF with Prescale 0.
    task automatic test_directed;
        logic [DW-1:0] tdata[4] = '{8'hA5, 8'h00, 8'h3C, 8'hFF};
        logic [PW-1:0] tps[4]   = '{6'd8, 6'd16, 6'd8, 6'd0};
        logic          tpar[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int t = 0; t < 4; t++) begin
            exp_tx.delete(); exp_busy.delete();
            add_frame(tdata[t], tps[t], tpar[t]);
            add_idle();
            P_DATA = tdata[t]; Prescale = tps[t]; Data_Valid = 1'b1;
`ifdef UART_TX_PARITY_EN
            PAR_TYP = tpar[t];
`endif
            @(posedge CLK); #1;
            Data_Valid = 1'b0;
            for (int k = 0; k < exp_tx.size(); k++) begin
                if (k > 0) begin @(posedge CLK); #1; end
                checks++;
                if (TX_OUT !== exp_tx[k] || Busy !== exp_busy[k]) begin
                    errors++;
                    $display("FAIL directed_%h cycle %0d: TX_OUT=%b Busy=%b, expected TX_OUT=%b Busy=%b",
                             tdata[t], k, TX_OUT, Busy, exp_tx[k], exp_busy[k]);
                end
            end
        end
    endtask

    // Random frames with input noise and ignored requests while busy.
    task automatic test_random;
        logic [DW-1:0] d;
        logic [PW-1:0] ps;
        logic          par;
        int            flen;
        for (int f = 0; f < 8; f++) begin
            d   = DW'($urandom);
            ps  = PW'($urandom_range(0, 10));
            par = 1'($urandom);
            exp_tx.delete(); exp_busy.delete();
            add_frame(d, ps, par);
            flen = exp_tx.size();
            add_idle();
            add_idle();
            P_DATA = d; Prescale = ps; Data_Valid = 1'b1;
`ifdef UART_TX_PARITY_EN
            PAR_TYP = par;
`endif
            @(posedge CLK); #1;
            for (int k = 0; k < exp_tx.size(); k++) begin
                if (k > 0) begin @(posedge CLK); #1; end
                checks++;
                if (TX_OUT !== exp_tx[k] || Busy !== exp_busy[k]) begin
                    errors++;
                    $display("FAIL random_f%0d_%h_ps%0d cycle %0d: TX_OUT=%b Busy=%b, expected TX_OUT=%b Busy=%b",
                             f, d, ps, k, TX_OUT, Busy, exp_tx[k], exp_busy[k]);
                end
                if (k < flen) begin
                    Data_Valid = 1'($urandom);
                    P_DATA     = DW'($urandom);
                    Prescale   = PW'($urandom);
`ifdef UART_TX_PARITY_EN
                    PAR_TYP    = 1'($urandom);
`endif
                end else begin
                    Data_Valid = 1'b0;
                end
            end
        end
    endtask

    // Data_Valid held high: 55 then FF, with exactly one idle cycle between frames.
    task automatic test_back_to_back;
        int flen;
        exp_tx.delete(); exp_busy.delete();
        add_frame(8'h55, PW'(8), 1'b0);
        flen = exp_tx.size();
        add_idle();
        add_frame(8'hFF, PW'(8), 1'b0);
        add_idle();
        P_DATA = 8'h55; Prescale = PW'(8); Data_Valid = 1'b1;
`ifdef UART_TX_PARITY_EN
        PAR_TYP = 1'b0;
`endif
        @(posedge CLK); #1;
        for (int k = 0; k < exp_tx.size(); k++) begin
            if (k > 0) begin @(posedge CLK); #1; end
            checks++;
            if (TX_OUT !== exp_tx[k] || Busy !== exp_busy[k]) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: TX_OUT=%b Busy=%b, expected TX_OUT=%b Busy=%b",
                         k, TX_OUT, Busy, exp_tx[k], exp_busy[k]);
            end
            if (k == 20) P_DATA = 8'hFF;
            if (k == flen + 1) Data_Valid = 1'b0;
        end
    endtask

    // Reset during data bit 3 aborts the frame; a clean frame follows.
    task automatic test_reset_mid_frame;
        exp_tx.delete(); exp_busy.delete();
        add_frame(8'hA5, PW'(4), 1'b0);
        P_DATA = 8'hA5; Prescale = PW'(4); Data_Valid = 1'b1;
`ifdef UART_TX_PARITY_EN
        PAR_TYP = 1'b0;
`endif
        @(posedge CLK); #1;
        Data_Valid = 1'b0;
        for (int k = 0; k <= 17; k++) begin
            if (k > 0) begin @(posedge CLK); #1; end
            checks++;
            if (TX_OUT !== exp_tx[k] || Busy !== exp_busy[k]) begin
                errors++;
                $display("FAIL pre_abort cycle %0d: TX_OUT=%b Busy=%b, expected TX_OUT=%b Busy=%b",
                         k, TX_OUT, Busy, exp_tx[k], exp_busy[k]);
            end
        end
        RST = 1'b0;
        @(posedge CLK); #1;
        checks++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_edge: TX_OUT=%b Busy=%b, expected TX_OUT=1 Busy=0", TX_OUT, Busy);
        end
        RST = 1'b1;
        repeat (3) begin
            @(posedge CLK); #1;
            checks++;
            if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
                errors++;
                $display("FAIL no_resume: TX_OUT=%b Busy=%b, expected TX_OUT=1 Busy=0", TX_OUT, Busy);
            end
        end
        exp_tx.delete(); exp_busy.delete();
        add_frame(8'h3C, PW'(8), 1'b0);
        add_idle();
        P_DATA = 8'h3C; Prescale = PW'(8); Data_Valid = 1'b1;
        @(posedge CLK); #1;
        Data_Valid = 1'b0;
        for (int k = 0; k < exp_tx.size(); k++) begin
            if (k > 0) begin @(posedge CLK); #1; end
            checks++;
            if (TX_OUT !== exp_tx[k] || Busy !== exp_busy[k]) begin
                errors++;
                $display("FAIL post_reset_3c cycle %0d: TX_OUT=%b Busy=%b, expected TX_OUT=%b Busy=%b",
                         k, TX_OUT, Busy, exp_tx[k], exp_busy[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
